// File: rtl/adc_dec_avg.sv
// Decimating boxcar averager: reduces the ADC sample rate by 2^k, emitting the block mean or the last sample,
// on a valid/ready port with sticky drop detection and a produced-result counter.
module adc_dec_avg #(
    parameter int DW   = 14,
    parameter int KMAX = 16,
    parameter int CW   = 32
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic [DW-1:0] adc_dat_i,
    input  logic          cfg_en_i,
    input  logic [4:0]    cfg_dec_log_i,
    input  logic          cfg_avg_i,
    input  logic          cfg_clr_i,
    output logic [DW-1:0] m_dat_o,
    output logic          m_vld_o,
    input  logic          m_rdy_i,
    output logic          ovf_o,
    output logic [CW-1:0] res_cnt_o
);

    localparam int AW = DW + KMAX;
    localparam logic [KMAX:0] ONE = (KMAX+1)'(1);

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;
    logic [KMAX-1:0]      cnt;
    logic [KMAX:0]        lim;
    logic [4:0]           k_act;
    logic [4:0]           k_cfg;
    logic [4:0]           k_eff;
    logic                 avg_act;
    logic                 avg_eff;
    logic                 last;
    logic                 prod;
    logic                 xfer;
    logic [DW-1:0]        res;

    // The first sample of a block already sees the freshly latched ratio/mode, so k=0 takes effect immediately.
    always_comb begin
        k_cfg   = (cfg_dec_log_i > 5'(KMAX)) ? 5'(KMAX) : cfg_dec_log_i;
        k_eff   = (cnt == '0) ? k_cfg : k_act;
        avg_eff = (cnt == '0) ? cfg_avg_i : avg_act;
        sum     = acc + {{KMAX{adc_dat_i[DW-1]}}, adc_dat_i};
        lim     = (ONE << k_eff) - ONE;
        last    = ({1'b0, cnt} == lim);
        res     = avg_eff ? DW'(sum >>> k_eff) : adc_dat_i;
        prod    = cfg_en_i && last;
        xfer    = m_vld_o && m_rdy_i;
    end

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            acc       <= '0;
            cnt       <= '0;
            k_act     <= '0;
            avg_act   <= 1'b0;
            m_dat_o   <= '0;
            m_vld_o   <= 1'b0;
            ovf_o     <= 1'b0;
            res_cnt_o <= '0;
        end else begin
            if (!cfg_en_i || last) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + KMAX'(1);
            end

            if (cfg_en_i && cnt == '0) begin
                k_act   <= k_cfg;
                avg_act <= cfg_avg_i;
            end

            if (prod) begin
                if (!m_vld_o || m_rdy_i) begin
                    m_dat_o <= res;
                    m_vld_o <= 1'b1;
                end else begin
                    ovf_o <= 1'b1;
                end
                res_cnt_o <= res_cnt_o + CW'(1);
            end else if (xfer) begin
                m_vld_o <= 1'b0;
            end

            // Clear overrides a same-cycle drop or count increment.
            if (cfg_clr_i) begin
                ovf_o     <= 1'b0;
                res_cnt_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_adc_dec_avg.sv
// Self-checking bench for adc_dec_avg: a behavioural block model pushes expected results into a
// scoreboard queue as samples are driven; scenario tasks pop and compare them against the DUT output.
module tb_adc_dec_avg;

    logic               adc_clk_i = 1'b0;
    logic               adc_rst_i = 1'b1;
    logic signed [13:0] adc_dat_i = '0;
    logic               cfg_en_i = 1'b0;
    logic [4:0]         cfg_dec_log_i = '0;
    logic               cfg_avg_i = 1'b0;
    logic               cfg_clr_i = 1'b0;
    logic signed [13:0] m_dat_o;
    logic               m_vld_o;
    logic               m_rdy_i = 1'b1;
    logic               ovf_o;
    logic [31:0]        res_cnt_o;

    adc_dec_avg #(.DW(14), .KMAX(16), .CW(32)) dut (
        .adc_clk_i(adc_clk_i),
        .adc_rst_i(adc_rst_i),
        .adc_dat_i(adc_dat_i),
        .cfg_en_i(cfg_en_i),
        .cfg_dec_log_i(cfg_dec_log_i),
        .cfg_avg_i(cfg_avg_i),
        .cfg_clr_i(cfg_clr_i),
        .m_dat_o(m_dat_o),
        .m_vld_o(m_vld_o),
        .m_rdy_i(m_rdy_i),
        .ovf_o(ovf_o),
        .res_cnt_o(res_cnt_o)
    );

    always #5 adc_clk_i = ~adc_clk_i;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic signed [13:0] sb[$];
    longint             m_acc = 0;
    int                 m_cnt = 0;
    int                 m_k = 0;
    bit                 m_avg = 1'b0;
    logic [31:0]        exp_cnt = '0;

    // Present one sample for one clock edge and advance the reference model.
    task automatic drive(input int x);
        logic signed [13:0] s;
        s = 14'(x);
        adc_dat_i = s;
        @(posedge adc_clk_i);
        #1;
        if (adc_rst_i) begin
            m_acc = 0;
            m_cnt = 0;
            exp_cnt = '0;
        end else if (!cfg_en_i) begin
            m_acc = 0;
            m_cnt = 0;
            if (cfg_clr_i) exp_cnt = '0;
        end else begin
            if (m_cnt == 0) begin
                m_k = (cfg_dec_log_i > 5'd16) ? 16 : int'(cfg_dec_log_i);
                m_avg = cfg_avg_i;
            end
            m_acc += longint'(s);
            m_cnt++;
            if (m_cnt == (1 << m_k)) begin
                if (m_avg) sb.push_back(14'(m_acc >>> m_k));
                else       sb.push_back(s);
                m_acc = 0;
                m_cnt = 0;
                exp_cnt = exp_cnt + 32'd1;
            end
            if (cfg_clr_i) exp_cnt = '0;
        end
    endtask

    // One disabled cycle flushes any partial block, then the new configuration is enabled.
    task automatic restart(input int k, input bit avg);
        cfg_en_i = 1'b0;
        cfg_dec_log_i = 5'(k);
        cfg_avg_i = avg;
        drive(0);
        cfg_en_i = 1'b1;
    endtask

    task automatic test_reset();
        adc_rst_i = 1'b1;
        drive(0);
        drive(0);
        total_cnt++;
        if (m_dat_o !== 14'sd0) $display("FAIL reset_dat: got %0d, required 0", m_dat_o); else pass_cnt++;
        total_cnt++;
        if (m_vld_o !== 1'b0) $display("FAIL reset_vld: got %b, required 0", m_vld_o); else pass_cnt++;
        total_cnt++;
        if (ovf_o !== 1'b0) $display("FAIL reset_ovf: got %b, required 0", ovf_o); else pass_cnt++;
        total_cnt++;
        if (res_cnt_o !== 32'd0) $display("FAIL reset_cnt: got %0d, required 0", res_cnt_o); else pass_cnt++;
        adc_rst_i = 1'b0;
    endtask

    task automatic test_avg_k2();
        int samples[5] = '{4, 8, -4, 12, 8};
        logic signed [13:0] e;
        cfg_dec_log_i = 5'd2;
        cfg_avg_i = 1'b1;
        cfg_en_i = 1'b1;
        m_rdy_i = 1'b1;
        foreach (samples[i]) begin
            drive(samples[i]);
            total_cnt++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (m_vld_o !== 1'b1 || m_dat_o !== e)
                    $display("FAIL avg_k2_result: vld=%b dat=%0d, required vld=1 dat=%0d", m_vld_o, m_dat_o, e);
                else pass_cnt++;
                total_cnt++;
                if (res_cnt_o !== exp_cnt) $display("FAIL avg_k2_cnt: got %0d, required %0d", res_cnt_o, exp_cnt);
                else pass_cnt++;
            end else begin
                if (m_vld_o !== 1'b0) $display("FAIL avg_k2_idle_vld: got %b, required 0", m_vld_o);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_truncation();
        int samples[6] = '{-3, -4, 8191, 8191, -8192, -8192};
        logic signed [13:0] e;
        restart(1, 1'b1);
        foreach (samples[i]) begin
            drive(samples[i]);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                total_cnt++;
                if (m_vld_o !== 1'b1 || m_dat_o !== e)
                    $display("FAIL trunc_result: vld=%b dat=%0d, required vld=1 dat=%0d", m_vld_o, m_dat_o, e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_passthrough();
        logic signed [13:0] e;
        restart(0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            drive(int'($urandom_range(0, 16383)));
            total_cnt++;
            if (sb.size() == 0) $display("FAIL pass_model: got no result, required one per sample");
            else begin
                e = sb.pop_front();
                if (m_vld_o !== 1'b1 || m_dat_o !== e)
                    $display("FAIL pass_result: vld=%b dat=%0d, required vld=1 dat=%0d", m_vld_o, m_dat_o, e);
                else pass_cnt++;
            end
        end
        restart(3, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(i);
            total_cnt++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (m_vld_o !== 1'b1 || m_dat_o !== e)
                    $display("FAIL last_sample_result: vld=%b dat=%0d, required vld=1 dat=%0d", m_vld_o, m_dat_o, e);
                else pass_cnt++;
            end else if (m_vld_o !== 1'b0) $display("FAIL last_sample_idle: got vld=%b, required 0", m_vld_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic signed [13:0] held;
        restart(0, 1'b1);
        m_rdy_i = 1'b0;
        drive(100);
        held = sb.pop_front();
        total_cnt++;
        if (m_vld_o !== 1'b1 || m_dat_o !== held || ovf_o !== 1'b0)
            $display("FAIL bp_first: vld=%b dat=%0d ovf=%b, required vld=1 dat=%0d ovf=0", m_vld_o, m_dat_o, ovf_o, held);
        else pass_cnt++;
        drive(200);
        void'(sb.pop_front());
        total_cnt++;
        if (ovf_o !== 1'b1 || m_dat_o !== held)
            $display("FAIL bp_drop: ovf=%b dat=%0d, required ovf=1 dat=%0d", ovf_o, m_dat_o, held);
        else pass_cnt++;
        drive(300);
        void'(sb.pop_front());
        total_cnt++;
        if (res_cnt_o !== exp_cnt || m_dat_o !== held)
            $display("FAIL bp_count: cnt=%0d dat=%0d, required cnt=%0d dat=%0d", res_cnt_o, m_dat_o, exp_cnt, held);
        else pass_cnt++;
        cfg_clr_i = 1'b1;
        drive(400);
        void'(sb.pop_front());
        cfg_clr_i = 1'b0;
        total_cnt++;
        if (ovf_o !== 1'b0 || res_cnt_o !== 32'd0)
            $display("FAIL clr_wins: ovf=%b cnt=%0d, required ovf=0 cnt=0", ovf_o, res_cnt_o);
        else pass_cnt++;
        total_cnt++;
        if (m_vld_o !== 1'b1 || m_dat_o !== held)
            $display("FAIL clr_keeps_data: vld=%b dat=%0d, required vld=1 dat=%0d", m_vld_o, m_dat_o, held);
        else pass_cnt++;
        m_rdy_i = 1'b1;
        cfg_en_i = 1'b0;
        drive(0);
        total_cnt++;
        if (m_vld_o !== 1'b0) $display("FAIL bp_drain: got vld=%b, required 0", m_vld_o); else pass_cnt++;
    endtask

    task automatic test_cfg_change();
        logic signed [13:0] e;
        restart(2, 1'b1);
        for (int i = 0; i < 12; i++) begin
            if (i == 2) cfg_dec_log_i = 5'd3;
            drive(i * 10 - 30);
            total_cnt++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (m_vld_o !== 1'b1 || m_dat_o !== e)
                    $display("FAIL cfg_change_result: sample %0d vld=%b dat=%0d, required vld=1 dat=%0d", i, m_vld_o, m_dat_o, e);
                else pass_cnt++;
            end else if (m_vld_o !== 1'b0) $display("FAIL cfg_change_idle: sample %0d vld=%b, required 0", i, m_vld_o);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid_block();
        int post[4] = '{20, -40, 60, 1};
        int seven[4] = '{7, 7, 7, 7};
        int fresh[4] = '{4, 4, 4, -4};
        logic signed [13:0] e;
        restart(2, 1'b1);
        drive(1000);
        drive(1000);
        drive(1000);
        adc_rst_i = 1'b1;
        drive(0);
        adc_rst_i = 1'b0;
        total_cnt++;
        if (m_dat_o !== 14'sd0 || m_vld_o !== 1'b0 || ovf_o !== 1'b0 || res_cnt_o !== 32'd0)
            $display("FAIL mid_reset_outputs: dat=%0d vld=%b ovf=%b cnt=%0d, required all 0", m_dat_o, m_vld_o, ovf_o, res_cnt_o);
        else pass_cnt++;
        foreach (post[i]) begin
            drive(post[i]);
            total_cnt++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (m_vld_o !== 1'b1 || m_dat_o !== e)
                    $display("FAIL post_reset_result: vld=%b dat=%0d, required vld=1 dat=%0d", m_vld_o, m_dat_o, e);
                else pass_cnt++;
            end else if (m_vld_o !== 1'b0) $display("FAIL post_reset_idle: got vld=%b, required 0", m_vld_o);
            else pass_cnt++;
        end
        foreach (seven[i]) begin
            if (i == 3) m_rdy_i = 1'b0;
            drive(seven[i]);
        end
        e = sb.pop_front();
        drive(1000);
        drive(1000);
        total_cnt++;
        if (m_vld_o !== 1'b1 || m_dat_o !== e)
            $display("FAIL pending_held: vld=%b dat=%0d, required vld=1 dat=%0d", m_vld_o, m_dat_o, e);
        else pass_cnt++;
        cfg_en_i = 1'b0;
        m_rdy_i = 1'b1;
        drive(0);
        cfg_en_i = 1'b1;
        total_cnt++;
        if (m_vld_o !== 1'b0) $display("FAIL disable_drain: got vld=%b, required 0", m_vld_o); else pass_cnt++;
        foreach (fresh[i]) begin
            drive(fresh[i]);
            total_cnt++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                if (m_vld_o !== 1'b1 || m_dat_o !== e)
                    $display("FAIL post_disable_result: vld=%b dat=%0d, required vld=1 dat=%0d", m_vld_o, m_dat_o, e);
                else pass_cnt++;
            end else if (m_vld_o !== 1'b0) $display("FAIL post_disable_idle: sample %0d vld=%b, required 0", i, m_vld_o);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_avg_k2();
        test_truncation();
        test_passthrough();
        test_backpressure();
        test_cfg_change();
        test_reset_mid_block();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL scoreboard_empty: %0d left, required 0", sb.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/adc_dec_avg.md
Name: adc_dec_avg

Overview:
- Decimating boxcar averager placed directly downstream of the equalization filter output (14-bit signed, one new sample every ADC clock).
- Reduces the sample rate by 2^k. Each output is either the mean or the last sample of each block of 2^k inputs.
- Results leave on a valid/ready port feeding the capture/splitter logic.
- Detects and flags results lost to consumer back-pressure.

Parameters:
- DW, 14, sample width (input and output, signed two's complement)
- KMAX, 16, maximum log2 decimation; accumulator width is DW+KMAX = 30
- CW, 32, width of the produced-result counter

Ports:
- adc_clk_i  in  1  ADC clock; all logic on the rising edge
- adc_rst_i  in  1  reset, synchronous, active-high
- adc_dat_i  in  DW  filtered ADC sample, signed, valid every cycle
- cfg_en_i  in  1  block enable
- cfg_dec_log_i  in  5  log2 of decimation ratio k; values > KMAX are treated as KMAX
- cfg_avg_i  in  1  1 = output block mean, 0 = output last sample of block
- cfg_clr_i  in  1  single-cycle pulse: clears ovf_o and res_cnt_o
- m_dat_o  out  DW  decimated sample, signed
- m_vld_o  out  1  m_dat_o holds an untransferred result
- m_rdy_i  in  1  consumer ready
- ovf_o  out  1  sticky: at least one result was dropped
- res_cnt_o  out  CW  number of results produced, including dropped ones; wraps

Behaviour:
- Reset (adc_rst_i=1 at an edge): acc=0, cnt=0, the latched ratio k_act=0, and the latched mode avg_act=0. All outputs are 0: m_dat_o, m_vld_o, ovf_o, res_cnt_o.
- Reset takes priority over every other input. It aborts a partial block, and the partial sum is discarded.
- Config latching: k_act and avg_act are loaded from cfg_* only when cnt==0 and cfg_en_i=1. A mid-block config change therefore takes effect at the next block start. k_act = min(cfg_dec_log_i, KMAX).
- Disabled (cfg_en_i=0): acc and cnt are forced to 0, and the partial block is discarded. The output register, m_vld_o and the handshake keep working, so a pending result can still be drained. ovf_o and res_cnt_o hold.
- Enabled, at each edge:
  - Define sum = acc + sign-extended adc_dat_i, 30 bits. It cannot overflow for k ≤ 16.
  - If cnt == 2^k_act − 1, a result is produced:
    - res = avg_act ? (sum >>> k_act) : adc_dat_i.
    - The shift is arithmetic and truncates toward −inf; take the low DW bits. These always fit.
    - Then acc←0, cnt←0.
  - Otherwise acc←sum and cnt←cnt+1.
- k_act=0 gives pass-through: a result is produced every cycle, and res = adc_dat_i.
- Latency: m_dat_o/m_vld_o update at the same edge that samples the last input of the block, i.e. they are visible 1 cycle after that sample is presented.
- Handshake: a transfer occurs at an edge where m_vld_o=1 and m_rdy_i=1. m_dat_o is stable while m_vld_o=1 and m_rdy_i=0.
- Result produced, per edge:
  - m_vld_o=0 → load res, m_vld_o←1.
  - m_vld_o=1 and m_rdy_i=1 → the transfer completes and res loads at the same edge; m_vld_o stays 1.
  - m_vld_o=1 and m_rdy_i=0 → res is dropped, m_dat_o is unchanged, ovf_o←1.
- No result produced, per edge: a transfer clears m_vld_o.
- res_cnt_o increments on every produced result, dropped or not, and wraps from 2^CW−1 to 0.
- cfg_clr_i: ovf_o←0 and res_cnt_o←0. When cfg_clr_i coincides with a drop or a production in the same cycle, the clear wins: ovf_o=0 and res_cnt_o=0 after that edge.
- All state lives in registers; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then enable with k=2, avg=1, m_rdy_i=1, inputs 4,8,−4,12,… → after the 4th sample, m_dat_o=5 with m_vld_o=1 for one cycle; res_cnt_o=1.
- k=1, avg=1, inputs −3,−4 → m_dat_o=−4 (−7>>>1, truncation toward −inf). Inputs 8191,8191 → 8191. Inputs −8192,−8192 → −8192.
- k=0 → m_dat_o tracks adc_dat_i with 1-cycle delay and m_vld_o held at 1. Then k=3, avg=0, inputs 0..7 → m_dat_o=7.
- k=0 with m_rdy_i=0 for 3 cycles → the first result is held; ovf_o=1 after the 2nd result; res_cnt_o=3. A cfg_clr_i pulse → ovf_o=0, res_cnt_o=0, with m_vld_o still 1 and the data still the first result.
- Change cfg_dec_log_i from 2 to 3 after the 2nd sample of a block → that block still ends after 4 samples; the next block spans 8 samples.
- Assert adc_rst_i after the 3rd of 4 samples, then release → all outputs 0. The next result uses only the 4 post-reset samples. cfg_en_i=0 mid-block gives the same block restart, and the pending m_vld_o result still drains.
